ysyx_24080014_lsu: RTL
======================

# ysyx_24080014_lsu

Load/store unit between the execute stage and the data memory bus. For each load or store presented by the core, it issues one request on a valid/ready memory interface and shifts and masks store data. It extracts and sign- or zero-extends load data. When the access completes, it pulses `mem_ready` for one cycle, which is the handshake `ysyx_24080014_gpr` uses to commit the load result or retire the store.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles spent in WAIT before the access is aborted with an error. Range 1..255.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `valid`  in  1  the current instruction is genuine.
- `load`  in  1  the instruction is a load; held until `mem_ready`.
- `StoreWr`  in  1  the instruction is a store; held until `mem_ready`.
- `funct3`  in  3  access size and signedness: `[1:0]` 00 = byte, 01 = half, 10 = word; `[2]` = unsigned (loads only).
- `addr`  in  32  effective byte address.
- `store_data`  in  32  rs2 value (unshifted).
- `load_data`  out  32  extended load result; drives `rd_data` of the gpr.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_err`  out  1  valid with `mem_ready`: misaligned access, bus error or timeout.
- `busy`  out  1  high when the FSM is not in IDLE.
- `mem_req_valid`  out  1  bus request valid.
- `mem_req_ready`  in  1  bus accepts the request.
- `mem_wen`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned address (`addr & ~3`).
- `mem_wdata`  out  32  shifted store data.
- `mem_wmask`  out  4  byte enables.
- `mem_rsp_valid`  in  1  response valid (reads and writes).
- `mem_rdata`  in  32  read word.
- `mem_rsp_err`  in  1  bus error, qualified by `mem_rsp_valid`.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- Start condition: in IDLE with `valid && (load || StoreWr)`.
  - On start, latch `addr`, `funct3`, `store_data` and `load` into internal registers.
  - `load` takes priority if both `load` and `StoreWr` are high.
- Start is ignored outside IDLE. Inputs may change freely while the FSM is busy; only the latched copies are used.
- Misaligned access (half with `addr[0]=1`, or word with `addr[1:0]!=0`): IDLE→DONE with `mem_err=1`. No bus request is issued and `load_data=0`.
- Otherwise IDLE→REQ.
- REQ:
  - `mem_req_valid=1`; `mem_addr`, `mem_wen`, `mem_wdata` and `mem_wmask` are held stable until accepted.
  - On `mem_req_ready`, go to WAIT.
  - If `mem_rsp_valid` is also high in the same cycle, go directly to DONE.
- WAIT:
  - On `mem_rsp_valid`, latch the result and go to DONE.
  - A cycle counter starts at 0 on entry. If it reaches `TIMEOUT` without a response, go to DONE with `mem_err=1` and `load_data=0`.
- DONE: `mem_ready=1` for exactly one cycle, then go to IDLE.
- `mem_err` = `mem_rsp_err` (or misaligned/timeout), registered alongside `load_data`.
- Store shaping, with `s = addr[1:0]*8`:
  - `mem_wdata = store_data << s`.
  - `mem_wmask`: byte `4'b0001<<addr[1:0]`, half `4'b0011<<addr[1:0]`, word `4'b1111`.
- Loads: `mem_wmask=0`, `mem_wen=0`.
- Load extraction: `r = mem_rdata >> s`.
  - Byte: `{{24{r[7]&~funct3[2]}}, r[7:0]}`.
  - Half: `{{16{r[15]&~funct3[2]}}, r[15:0]}`.
  - Word: `r`.
- For stores, `load_data` is 0.
- `funct3[1:0]=11` is treated as word.

## Timing
- Reset values:
  - State IDLE.
  - `mem_ready`, `mem_err`, `busy`, `mem_req_valid`, `mem_wen` = 0.
  - `load_data`, `mem_addr`, `mem_wdata` = 0; `mem_wmask` = 0.
  - Counter 0.
- Reset asserted mid-access: the FSM returns to IDLE immediately, `mem_req_valid` drops asynchronously, and any late response is ignored.
- All outputs are registered; no combinational path from bus inputs to outputs.
- Latency, with start at cycle 0:
  - `mem_req_valid` is high from cycle 1.
  - If the bus is ready and responds in the same cycle, `mem_ready` is high in cycle 2.
  - Each bus wait cycle adds 1.
  - Misaligned access: `mem_ready` in cycle 1.
- `load_data` is valid in the same cycle as `mem_ready` and holds until the next completion.
- A new start is possible in the cycle after DONE, i.e. a back-to-back access every 3 cycles minimum.
- `mem_rsp_valid` is ignored in IDLE, DONE, and in REQ before acceptance.

## Test plan
- LB from `addr=0x80000003`, `mem_rdata=0x80112233`, bus ready with a same-cycle response:
  - `mem_addr=0x80000000`;
  - `load_data=0xFFFFFF80` with `mem_ready` pulse in cycle 2;
  - LBU gives `0x00000080`.
- SH `store_data=0x0000ABCD` at `addr=0x102`:
  - `mem_wdata=0xABCD0000`, `mem_wmask=4'b1100`, `mem_wen=1`;
  - the request is held 3 cycles while `mem_req_ready=0`, with no change on the bus fields.
- LW from `addr=0x101`: misaligned, so `mem_ready` and `mem_err=1` in cycle 1, `mem_req_valid` never asserted, `load_data=0`.
- With `TIMEOUT=4`, request accepted, no response: `mem_err=1` and `mem_ready` exactly 4 cycles after entering WAIT; the FSM returns to IDLE.
- `rst_n` low while in WAIT:
  - all outputs return to reset values immediately;
  - a response arriving afterwards produces no `mem_ready`.
- Back-to-back: LW `0x200` → `0x12345678`, then `valid` high with `StoreWr` during busy is ignored until IDLE; the second access starts exactly the cycle after DONE.

Source files
------------

// File: rtl/ysyx_24080014_lsu.sv
// Load/store unit: one valid/ready bus request per load or store. Store data
// is shifted and byte-masked on the way out. Load data is extracted and
// extended on the way back. A one-cycle mem_ready pulse marks completion.
module ysyx_24080014_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        load,
  input  logic        StoreWr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic        is_load_q, is_load_d;
  logic [31:0] load_data_q, load_data_d;
  logic        mem_ready_q, mem_ready_d;
  logic        mem_err_q, mem_err_d;
  logic        busy_q, busy_d;
  logic        req_valid_q, req_valid_d;
  logic        wen_q, wen_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;

  logic        start;
  logic        misaligned;

  // Pick the addressed byte/half/word out of the read word and extend it.
  function automatic logic [31:0] extract(input logic [31:0] rdata,
                                          input logic [1:0]  off,
                                          input logic [2:0]  f3);
    logic [31:0] r;
    r = rdata >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   return {{24{r[7] & ~f3[2]}}, r[7:0]};
      2'b01:   return {{16{r[15] & ~f3[2]}}, r[15:0]};
      default: return r;
    endcase
  endfunction

  assign start      = valid && (load || StoreWr);
  // funct3[1] set means word (11 is treated as word).
  assign misaligned = (funct3[1] && (addr[1:0] != 2'b00)) ||
                      (!funct3[1] && funct3[0] && addr[0]);

  // Next-state and next-output logic; every output is a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    f3_d        = f3_q;
    is_load_d   = is_load_q;
    load_data_d = load_data_q;
    mem_ready_d = 1'b0;
    mem_err_d   = 1'b0;
    req_valid_d = req_valid_q;
    wen_d       = wen_q;
    maddr_d     = maddr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          off_d     = addr[1:0];
          f3_d      = funct3;
          is_load_d = load;
          maddr_d   = {addr[31:2], 2'b00};
          wen_d     = ~load;
          wdata_d   = load ? 32'd0 : store_data << {addr[1:0], 3'b000};
          if (load)                 wmask_d = 4'b0000;
          else if (funct3[1])       wmask_d = 4'b1111;
          else if (funct3[0])       wmask_d = 4'b0011 << addr[1:0];
          else                      wmask_d = 4'b0001 << addr[1:0];
          if (misaligned) begin
            state_d     = S_DONE;
            mem_ready_d = 1'b1;
            mem_err_d   = 1'b1;
            load_data_d = 32'd0;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          cnt_d       = 8'd0;
          if (mem_rsp_valid) begin
            state_d     = S_DONE;
            mem_ready_d = 1'b1;
            mem_err_d   = mem_rsp_err;
            load_data_d = is_load_q ? extract(mem_rdata, off_q, f3_q) : 32'd0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          state_d     = S_DONE;
          mem_ready_d = 1'b1;
          mem_err_d   = mem_rsp_err;
          load_data_d = is_load_q ? extract(mem_rdata, off_q, f3_q) : 32'd0;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d     = S_DONE;
          mem_ready_d = 1'b1;
          mem_err_d   = 1'b1;
          load_data_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // FSM state and registered outputs; reset drops the request asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
      is_load_q   <= 1'b0;
      load_data_q <= 32'd0;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      req_valid_q <= 1'b0;
      wen_q       <= 1'b0;
      maddr_q     <= 32'd0;
      wdata_q     <= 32'd0;
      wmask_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      is_load_q   <= is_load_d;
      load_data_q <= load_data_d;
      mem_ready_q <= mem_ready_d;
      mem_err_q   <= mem_err_d;
      busy_q      <= busy_d;
      req_valid_q <= req_valid_d;
      wen_q       <= wen_d;
      maddr_q     <= maddr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
    end
  end

  assign load_data     = load_data_q;
  assign mem_ready     = mem_ready_q;
  assign mem_err       = mem_err_q;
  assign busy          = busy_q;
  assign mem_req_valid = req_valid_q;
  assign mem_wen       = wen_q;
  assign mem_addr      = maddr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

endmodule
